pw_check: RTL and testbench
===========================

PW_CHECK -- requirements
Module: pw_check

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMEOUT_CYCLES, 1000, idle cycles allowed between digits before entry is discarded.
- UNLOCK_CYCLES, 500, cycles unlock stays high after a match.
- LOCKOUT_CYCLES, 5000, cycles alarm stays high after the final failure.
- MAX_FAIL, 3, consecutive mismatches that trigger lockout.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line: name  direction  width  meaning.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- digit_valid  in  1  single-cycle strobe qualifying digit.
- digit  in  4  entered digit, BCD.
- clear  in  1  abort current entry.
- key0..key3  in  4 each  stored password digits, key0 entered first.
- unlock  out  1  registered open indication.
- alarm  out  1  registered lockout indication.
- fail_cnt  out  2  consecutive mismatch count.
- digit_cnt  out  3  digits collected in the current entry, 0..4.
- busy  out  1  high in CHECK, OPEN or LOCKOUT.

Function
REQ-003 The FSM SHALL have states IDLE, ENTRY, CHECK, OPEN and LOCKOUT.
REQ-004 A digit SHALL be accepted only when digit_valid=1, digit<=9, and the state is IDLE or ENTRY; digits 10..15 are dropped with no state or counter change.
REQ-005 An accepted digit SHALL be written to buf[digit_cnt], and digit_cnt SHALL increment; the first accepted digit SHALL move IDLE to ENTRY.
REQ-006 Acceptance of the 4th digit at edge N SHALL enter CHECK for exactly one cycle, comparing buf[0..3] against key0..key3 as sampled in that cycle.
REQ-007 On a match, the block SHALL enter OPEN at edge N+2, with unlock=1 from edge N+2 for exactly UNLOCK_CYCLES cycles; fail_cnt SHALL clear to 0; the block SHALL then return to IDLE.
REQ-008 On a mismatch, fail_cnt SHALL increment. If the new value equals MAX_FAIL, the block SHALL enter LOCKOUT; otherwise it SHALL enter IDLE. In both cases digit_cnt SHALL clear to 0.
REQ-009 In LOCKOUT, alarm SHALL be 1 for exactly LOCKOUT_CYCLES cycles; the block SHALL then enter IDLE with fail_cnt=0.
REQ-010 In ENTRY, clear=1 SHALL return the block to IDLE at the next edge, with digit_cnt=0 and fail_cnt unchanged.
REQ-011 In ENTRY, TIMEOUT_CYCLES consecutive cycles without an accepted digit SHALL return the block to IDLE with digit_cnt=0; a timeout is not a failure.
REQ-012 clear and digit_valid SHALL be ignored in CHECK, OPEN and LOCKOUT.
REQ-013 If clear and a valid digit arrive in the same cycle in ENTRY, clear SHALL win and the digit SHALL be dropped.
REQ-014 key0..key3 SHALL be read only in CHECK; changing the keys during ENTRY SHALL affect only the pending comparison.

Reset
REQ-015 reset=0 SHALL force, asynchronously: state=IDLE, unlock=0, alarm=0, fail_cnt=0, digit_cnt=0, busy=0, buf=0, and all timers cleared.
REQ-016 A reset asserted mid-entry, mid-OPEN or mid-LOCKOUT SHALL abort the operation; operation SHALL resume from IDLE after release.

Structure
REQ-017 Package pw_pkg SHALL hold the state enumeration, DIGIT_W=4, NUM_DIGITS=4 and MAX_DIGIT=9.
REQ-018 A single sub-module, pw_timer, SHALL be used: a loadable down-counter with a done flag, shared by the timeout, unlock and lockout timing.

Verification
REQ-019 The bench SHALL use TIMEOUT_CYCLES=16, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=32, MAX_FAIL=3 and keys 6,6,6,6, and SHALL cover:
- Digits 6,6,6,6 -> unlock=1 exactly 2 cycles after the 4th strobe, held 8 cycles; fail_cnt=0.
- Digits 1,2,3,4 three times -> fail_cnt 1 then 2; on the 3rd attempt alarm=1 for 32 cycles; fail_cnt=0 afterwards; digits during alarm are ignored.
- Digits 6,6 then 16 idle cycles -> digit_cnt=0, fail_cnt unchanged; then 6,6,6,6 -> unlock.
- Digits 6,6,6 with clear and digit=6 in the same cycle -> IDLE, digit_cnt=0, no unlock.
- Digits 6,0xA,6,6,6 -> the 0xA is dropped and unlock is asserted.
- Reset pulsed at cycle 3 of OPEN -> unlock=0 immediately; state=IDLE.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared definitions for the password checker.
// Holds the FSM state enumeration, the digit and buffer geometry, and a small
// helper that classifies an incoming nibble as a decimal digit.
package pw_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_DIGIT  = 9;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } pw_state_t;

    function automatic logic is_decimal(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter shared by the entry timeout, the unlock hold time and
// the lockout hold time. Only one of those is ever running at once.
//   clk, reset : clock and asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load; a hold of N cycles is loaded as N-1
//   done       : counter has reached zero
module pw_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pw_check.sv
// Four-digit password checker with entry timeout, timed unlock and lockout
// after repeated failures.
//   clk, reset        : clock and asynchronous active-low reset
//   digit_valid/digit : one-cycle strobe with a BCD digit; 10..15 are dropped
//   clear             : abandon the entry in progress
//   key0..key3        : stored password, key0 entered first
//   unlock            : registered, high for UNLOCK_CYCLES after a match
//   alarm             : registered, high for LOCKOUT_CYCLES after MAX_FAIL misses
//   fail_cnt          : consecutive mismatch count
//   digit_cnt         : digits collected in the current entry
//   busy              : high in CHECK, OPEN or LOCKOUT
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first digit
// ENTRY   | collecting digits; timeout running between digits
// CHECK   | one cycle: compare buffer against keys
// OPEN    | unlock held for UNLOCK_CYCLES
// LOCKOUT | alarm held for LOCKOUT_CYCLES
module pw_check
    import pw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int MAX_FAIL       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] key0,
    input  logic [DIGIT_W-1:0] key1,
    input  logic [DIGIT_W-1:0] key2,
    input  logic [DIGIT_W-1:0] key3,
    output logic               unlock,
    output logic               alarm,
    output logic [1:0]         fail_cnt,
    output logic [CNT_W-1:0]   digit_cnt,
    output logic               busy
);

    localparam int T_MAX0 = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
    localparam int T_MAX  = (T_MAX0 > LOCKOUT_CYCLES) ? T_MAX0 : LOCKOUT_CYCLES;
    localparam int TW     = $clog2(T_MAX + 1);

    pw_state_t          state_q;
    pw_state_t          state_d;
    logic [DIGIT_W-1:0] dig_buf [NUM_DIGITS];

    logic               accept;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_done;
    logic               match;
    logic [2:0]         fail_inc;
    logic               digit_ok;
    logic               buf_full;

    pw_timer #(
        .WIDTH    (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign buf_full = (digit_cnt == CNT_W'(NUM_DIGITS));
    assign digit_ok = digit_valid && is_decimal(digit) && !buf_full;
    assign match    = ({dig_buf[0], dig_buf[1], dig_buf[2], dig_buf[3]} ==
                       {key0, key1, key2, key3});
    assign fail_inc = {1'b0, fail_cnt} + 3'd1;
    assign busy     = (state_q == ST_CHECK) || (state_q == ST_OPEN) ||
                      (state_q == ST_LOCKOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The cycle after the 4th digit is spent in ENTRY with a full buffer, so
    // CHECK runs one cycle later and OPEN/LOCKOUT land two edges after the
    // final digit is taken.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (digit_ok) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                    state_d  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (buf_full) begin
                    state_d = ST_CHECK;
                end else if (digit_ok) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    state_d  = ST_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(UNLOCK_CYCLES - 1);
                end else if (fail_inc == 3'(MAX_FAIL)) begin
                    state_d  = ST_LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOCKOUT_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_buf[i] <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            if (accept) begin
                dig_buf[digit_cnt[1:0]] <= digit;
                digit_cnt               <= digit_cnt + 1'b1;
            end
            if (state_q == ST_ENTRY && state_d == ST_IDLE) begin
                digit_cnt <= '0;
            end
            if (state_q == ST_CHECK) begin
                digit_cnt <= '0;
                fail_cnt  <= match ? 2'd0 : fail_inc[1:0];
            end
            if (state_q == ST_LOCKOUT && state_d == ST_IDLE) begin
                fail_cnt <= '0;
            end
            unlock <= (state_d == ST_OPEN);
            alarm  <= (state_d == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_pw_check.sv
module tb_pw_check;

    localparam int T_TO   = 16;
    localparam int T_UNL  = 8;
    localparam int T_LOCK = 32;
    localparam int MAXF   = 3;
    localparam logic [3:0] KEY = 4'd6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clear = 1'b0;
    logic [3:0] key0 = KEY, key1 = KEY, key2 = KEY, key3 = KEY;
    logic       unlock, alarm, busy;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    pw_check #(
        .TIMEOUT_CYCLES (T_TO),
        .UNLOCK_CYCLES  (T_UNL),
        .LOCKOUT_CYCLES (T_LOCK),
        .MAX_FAIL       (MAXF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .key0        (key0),
        .key1        (key1),
        .key2        (key2),
        .key3        (key3),
        .unlock      (unlock),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt),
        .digit_cnt   (digit_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Expected change of the observable outcome {unlock, alarm, fail_cnt}
    // together with the clock edge at which it must appear.
    typedef struct packed {
        logic        u;
        logic        a;
        logic [1:0]  f;
        int unsigned c;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state: digits entered so far and consecutive misses.
    int entered[$];
    int mf = 0;
    int unsigned ready = 0;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: any change of unlock/alarm/fail_cnt is a response to score.
    logic [3:0] prev_obs;
    initial begin
        prev_obs = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_obs = {unlock, alarm, fail_cnt};
            end else if ({unlock, alarm, fail_cnt} != prev_obs) begin
                ev_t act, e;
                act = '{u: unlock, a: alarm, f: fail_cnt, c: cyc};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got u=%0b a=%0b f=%0d at cycle %0d, none expected",
                             unlock, alarm, fail_cnt, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (act != e) begin
                        fails++;
                        $display("FAIL outcome_event: got u=%0b a=%0b f=%0d cyc=%0d expected u=%0b a=%0b f=%0d cyc=%0d",
                                 act.u, act.a, act.f, act.c, e.u, e.a, e.f, e.c);
                    end
                end
                prev_obs = {unlock, alarm, fail_cnt};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] d, output int unsigned n);
        digit       = d;
        digit_valid = 1'b1;
        @(posedge clk);
        #1;
        n           = cyc;
        digit_valid = 1'b0;
    endtask

    // The whole attempt is judged from the four digits and the miss history.
    task automatic resolve(input int unsigned n);
        bit ok;
        ok = 1'b1;
        foreach (entered[i]) if (entered[i] != int'(KEY)) ok = 1'b0;
        if (ok) begin
            exp_q.push_back('{u: 1'b1, a: 1'b0, f: 2'd0, c: n + 2});
            exp_q.push_back('{u: 1'b0, a: 1'b0, f: 2'd0, c: n + 2 + T_UNL});
            mf    = 0;
            ready = n + 2 + T_UNL;
        end else begin
            mf++;
            if (mf == MAXF) begin
                exp_q.push_back('{u: 1'b0, a: 1'b1, f: 2'(MAXF), c: n + 2});
                exp_q.push_back('{u: 1'b0, a: 1'b0, f: 2'd0, c: n + 2 + T_LOCK});
                mf    = 0;
                ready = n + 2 + T_LOCK;
            end else begin
                exp_q.push_back('{u: 1'b0, a: 1'b0, f: 2'(mf), c: n + 2});
                ready = n + 2;
            end
        end
        entered.delete();
    endtask

    task automatic enter(input logic [3:0] d);
        int unsigned n;
        send(d, n);
        if (d <= 4'd9) begin
            entered.push_back(int'(d));
            chk("digit_cnt_after_digit", int'(digit_cnt), entered.size());
            if (entered.size() == 4) resolve(n);
        end else begin
            chk("digit_cnt_after_bad_digit", int'(digit_cnt), entered.size());
        end
    endtask

    task automatic enter_code(input logic [3:0] a, b, c, d);
        enter(a); enter(b); enter(c); enter(d);
    endtask

    initial begin
        int unsigned n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_unlock", int'(unlock), 0);
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        chk("reset_digit_cnt", int'(digit_cnt), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        idle(2);

        // correct code opens
        enter_code(KEY, KEY, KEY, KEY);
        idle_until(ready);
        chk("open_fail_cnt", int'(fail_cnt), 0);

        // three misses lead to lockout; digits during the alarm are ignored
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle_until(ready);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle_until(ready);
        enter_code(4'd1, 4'd2, 4'd3, 4'd4);
        idle(3);
        chk("lockout_alarm", int'(alarm), 1);
        for (int i = 0; i < 4; i++) begin
            send(KEY, n);
            chk("lockout_digit_ignored", int'(digit_cnt), 0);
            chk("lockout_busy", int'(busy), 1);
        end
        idle_until(ready);
        chk("after_lockout_fail_cnt", int'(fail_cnt), 0);
        chk("after_lockout_alarm", int'(alarm), 0);

        // timeout discards a partial entry without counting a miss
        enter_code(4'd1, 4'd1, 4'd1, 4'd1);
        idle_until(ready);
        enter(KEY);
        enter(KEY);
        idle(T_TO - 1);
        chk("timeout_not_yet", int'(digit_cnt), 2);
        idle(1);
        chk("timeout_digit_cnt", int'(digit_cnt), 0);
        chk("timeout_fail_cnt", int'(fail_cnt), mf);
        entered.delete();
        enter_code(KEY, KEY, KEY, KEY);
        idle_until(ready);

        // clear beats a digit in the same cycle
        enter(KEY); enter(KEY); enter(KEY);
        clear = 1'b1;
        send(KEY, n);
        clear = 1'b0;
        chk("clear_digit_cnt", int'(digit_cnt), 0);
        entered.delete();
        idle(12);
        chk("clear_no_unlock", int'(unlock), 0);
        chk("clear_idle", int'(busy), 0);

        // non-decimal digit is dropped
        enter(KEY);
        enter(4'hA);
        enter(KEY); enter(KEY); enter(KEY);
        idle_until(ready);

        // reset during the third cycle of OPEN
        enter_code(KEY, KEY, KEY, KEY);
        idle_until(n + 0);
        idle_until(ready - T_UNL + 2);
        reset = 1'b0;
        exp_q.delete();
        entered.delete();
        mf = 0;
        #1;
        chk("reset_open_unlock", int'(unlock), 0);
        chk("reset_open_busy", int'(busy), 0);
        chk("reset_open_digit_cnt", int'(digit_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        ready = cyc;
        enter_code(KEY, KEY, KEY, KEY);
        idle_until(ready);

        // randomized attempts with invalid digits and short gaps mixed in
        for (int a = 0; a < 20; a++) begin
            bit good;
            good = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 4; i++) begin
                idle($urandom_range(0, 4));
                if ($urandom_range(0, 3) == 0) enter(4'(10 + $urandom_range(0, 5)));
                if (good) enter(KEY);
                else enter(4'($urandom_range(0, 9)));
            end
            idle_until(ready);
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
